// File: rtl/stream_decryptor.sv
// ---------------------------------------------------------------------------
// stream_decryptor
//
// Two-stage pipelined decryptor for words of DIGITS cipher nibbles. Each
// digit is XORed with a keystream nibble (keyed mode) or passed through
// (plain mode), then excess-3 decoded: p = (c ^ k) - 3, modulo 16.
// The keystream comes from a 16-bit Fibonacci LFSR
// (x^16 + x^14 + x^13 + x^11 + 1) that steps once per accepted keyed word.
//
// Optional feature macro: STREAM_DECRYPTOR_ERRCHK_EN
//   defined   -> per-digit invalid-BCD flags and a saturating error counter
//   undefined -> out_err and err_cnt are tied to zero
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   mode       0 = excess-3 only, 1 = keyed (sampled with each accepted word)
//   key_load   load LFSR seed from key_in (blocks acceptance that cycle)
//   key_in     LFSR seed; zero is replaced by 16'hACE1
//   in_data    cipher word, digit i = in_data[4i+3:4i]
//   in_valid   in_data is valid
//   in_ready   word is accepted when in_valid && in_ready
//   out_data   plaintext word
//   out_err    per-digit flag, decoded digit > 9
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data
//   err_cnt    saturating count of transferred words with any error flag
// ---------------------------------------------------------------------------
module stream_decryptor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  key_load,
  input  logic [15:0]           key_in,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            err_cnt
);

  localparam int          W        = 4 * DIGITS;
  localparam logic [15:0] LFSR_RST = 16'hACE1;

  logic          lfsr_fb;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          s1_v_q, s1_v_d;
  logic [W-1:0]  s1_x_q, s1_x_d;
  logic          s2_v_q, s2_v_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [W-1:0]  key_word;
  logic [W-1:0]  plain_word;
  logic          adv;
  logic          accept;

  // The whole pipeline moves together: it may advance whenever the output
  // register is empty or is being drained this cycle.
  assign adv      = !s2_v_q || out_ready;
  assign in_ready = adv && !key_load;
  assign accept   = in_valid && in_ready;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Keystream nibbles repeat every four digits; in plain mode the key is
  // masked to zero here, so stage 1 already holds the mode-resolved value
  // and mode needs no separate pipeline register.
  always_comb begin
    key_word = '0;
    for (int i = 0; i < DIGITS; i++) begin
      key_word[4*i +: 4] = mode ? lfsr_q[4*(i%4) +: 4] : 4'h0;
    end
  end

  // Excess-3 removal; wrap-around below zero is intentional.
  always_comb begin
    plain_word = '0;
    for (int i = 0; i < DIGITS; i++) begin
      plain_word[4*i +: 4] = s1_x_q[4*i +: 4] - 4'd3;
    end
  end

  // LFSR next state: key_load wins over stepping, and a zero seed would
  // lock the register up, so it is replaced by the reset seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (key_load) begin
      lfsr_d = (key_in == 16'h0000) ? LFSR_RST : key_in;
    end else if (accept && mode) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Pipeline next state. Data registers only load when a real word moves
  // into them, so bubbles leave the previous contents in place.
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_x_d     = s1_x_q;
    s2_v_d     = s2_v_q;
    out_data_d = out_data_q;
    if (adv) begin
      s1_v_d = accept;
      s2_v_d = s1_v_q;
      if (accept) begin
        s1_x_d = in_data ^ key_word;
      end
      if (s1_v_q) begin
        out_data_d = plain_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= LFSR_RST;
      s1_v_q     <= 1'b0;
      s1_x_q     <= '0;
      s2_v_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      s1_v_q     <= s1_v_d;
      s1_x_q     <= s1_x_d;
      s2_v_q     <= s2_v_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = s2_v_q;

`ifdef STREAM_DECRYPTOR_ERRCHK_EN
  logic [DIGITS-1:0] out_err_q, out_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // Error flags travel with the data into stage 2; the counter only counts
  // words that actually leave the block, and sticks at 255.
  always_comb begin
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;
    if (adv && s1_v_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        out_err_d[i] = plain_word[4*i +: 4] > 4'd9;
      end
    end
    if (s2_v_q && out_ready && (|out_err_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q <= '0;
      err_cnt_q <= '0;
    end else begin
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign out_err = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_decryptor.sv
// ---------------------------------------------------------------------------
// tb_stream_decryptor
//
// Directed bench for stream_decryptor (DIGITS = 4). Expected plaintext is
// hand-computed from the excess-3 / LFSR keystream rules. Works with the
// STREAM_DECRYPTOR_ERRCHK_EN macro either defined or undefined.
// ---------------------------------------------------------------------------
module tb_stream_decryptor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        key_load;
  logic [15:0] key_in;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;

  int err_count   = 0;
  int check_count = 0;

`ifdef STREAM_DECRYPTOR_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  stream_decryptor #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one word for one cycle; it must be accepted immediately.
  task automatic applyStimulus(input string tag, input logic m, input logic [15:0] word);
    mode     = m;
    in_data  = word;
    in_valid = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Send a word and check the fixed two-cycle latency and one-cycle output.
  task automatic sendAndCheck(input string tag, input logic m, input logic [15:0] word,
                              input logic [15:0] exp_data, input logic [3:0] exp_err);
    applyStimulus(tag, m, word);
    checkOutput({tag, "_valid_t1"}, out_valid, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_t2"}, out_valid, 1);
    checkOutput({tag, "_data"}, out_data, exp_data);
    checkOutput({tag, "_err"}, out_err, ERRCHK ? exp_err : 4'b0000);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_t3"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] word_in;
    logic [15:0] word_exp;
    int          sent;
    int          got;

    rst       = 1'b1;
    mode      = 1'b0;
    key_load  = 1'b0;
    key_in    = 16'h0000;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] plain and keyed decode");
    sendAndCheck("plain", 1'b0, 16'h3456, 16'h0123, 4'b0000);
    // Seed ACE1 gives key nibbles 1,E,C,A for digits 0..3.
    sendAndCheck("keyed0", 1'b1, 16'h9FD2, 16'h0000, 4'b0000);
    // One LFSR step later: 59C3 -> key nibbles 3,C,9,5.
    sendAndCheck("keyed1", 1'b1, 16'h6AF0, 16'h0000, 4'b0000);

    $display("[TB] wrap-around and error flags");
    sendAndCheck("wrap", 1'b0, 16'hD350, 16'hA02D, 4'b1001);
    checkOutput("wrap_err_cnt", err_cnt, ERRCHK ? 1 : 0);

    $display("[TB] key_load with zero key");
    key_load = 1'b1;
    key_in   = 16'h0000;
    mode     = 1'b1;
    in_data  = 16'h1111;
    in_valid = 1'b1;
    #1;
    checkOutput("kl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("kl_no_accept_t1", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("kl_no_accept_t2", out_valid, 0);
    // Plain word must not step the LFSR; the keyed word sees seed ACE1.
    sendAndCheck("kl_plain", 1'b0, 16'h3456, 16'h0123, 4'b0000);
    sendAndCheck("kl_keyed", 1'b1, 16'h9FD2, 16'h0000, 4'b0000);

    $display("[TB] key_load with key 0x1234");
    key_load = 1'b1;
    key_in   = 16'h1234;
    @(posedge clk); #1;
    key_load = 1'b0;
    sendAndCheck("kl_1234", 1'b1, 16'h2107, 16'h0000, 4'b0000);

    $display("[TB] back-to-back stream with stall");
    word_in  = 16'h3333;
    word_exp = 16'h0000;
    sent     = 0;
    got      = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      mode      = 1'b0;
      in_valid  = (sent < 6);
      in_data   = word_in;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c <= 8) checkOutput($sformatf("stall_in_ready_c%0d", c), in_ready, !(c >= 3 && c <= 5));
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stall_data_%0d", got), out_data, word_exp);
        word_exp = word_exp + 16'h1111;
        got++;
      end
      if (in_valid && in_ready) begin
        word_in = word_in + 16'h1111;
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stall_count", got, 6);
    checkOutput("stall_drain", out_valid, 0);

    $display("[TB] reset with two words in flight");
    out_ready = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hD350;
    @(posedge clk); #1;
    in_data   = 16'h3456;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    checkOutput("flush_inflight", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_err_cnt", err_cnt, 0);
    checkOutput("flush_out_data", out_data, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("flush_quiet_%0d", i), out_valid, 0);
    end
    // LFSR must be back at the reset seed.
    sendAndCheck("post_rst", 1'b1, 16'h9FD2, 16'h0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
